// File: rtl/el2_pkg.sv
// rtl/el2_pkg.sv - shared types for the EL2 LSU committed-store queue
package el2_pkg;

  // Widest byte address an entry can hold; the queue's ADDR_W must not exceed it.
  localparam int EL2_STQ_MAX_ADDR_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    VLD  = 1'b1
  } el2_stq_state_e;

  typedef struct packed {
    logic [EL2_STQ_MAX_ADDR_W-1:0] addr;    // word-aligned byte address, bits [1:0] = 0
    logic [31:0]                   data;
    logic [3:0]                    byteen;
    el2_stq_state_e                state;
  } el2_stq_entry_t;

endpackage

// File: rtl/el2_lsu_stq_if.sv
// rtl/el2_lsu_stq_if.sv - store-allocate and DCCM-drain handshake of the store queue
interface el2_lsu_stq_if #(
  parameter int ADDR_W = 16
);
  // R-stage store allocation
  logic              ldst_stbuf_reqvld_r;
  logic [ADDR_W-1:0] store_addr_r;
  logic [31:0]       store_data_r;
  logic [3:0]        store_byteen_r;

  // head-of-queue DCCM write request and its acceptance
  logic              stbuf_reqvld_any;
  logic [ADDR_W-1:0] stbuf_addr_any;
  logic [31:0]       stbuf_data_any;
  logic [3:0]        stbuf_byteen_any;
  logic              lsu_stbuf_commit_any;

  modport master (
    output ldst_stbuf_reqvld_r, store_addr_r, store_data_r, store_byteen_r,
    output lsu_stbuf_commit_any,
    input  stbuf_reqvld_any, stbuf_addr_any, stbuf_data_any, stbuf_byteen_any
  );

  modport slave (
    input  ldst_stbuf_reqvld_r, store_addr_r, store_data_r, store_byteen_r,
    input  lsu_stbuf_commit_any,
    output stbuf_reqvld_any, stbuf_addr_any, stbuf_data_any, stbuf_byteen_any
  );
endinterface

// File: rtl/el2_lsu_stq_fwd.sv
// rtl/el2_lsu_stq_fwd.sv - youngest-wins per-byte store-to-load forwarding mux
module el2_lsu_stq_fwd
  import el2_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  localparam int IW    = $clog2(DEPTH)
) (
  input  el2_stq_entry_t    ent [DEPTH],
  input  logic [IW-1:0]     rd_idx,
  input  logic [ADDR_W-1:0] ld_addr_m,
  output logic [31:0]       fwddata,
  output logic [3:0]        fwdbyteen
);
  logic unused_ld_lsbs;
  assign unused_ld_lsbs = ^ld_addr_m[1:0];

  // Walk from oldest to youngest so a younger matching byte overrides an older one.
  always_comb begin
    fwddata   = '0;
    fwdbyteen = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent[rd_idx + IW'(k)].state == VLD &&
          ent[rd_idx + IW'(k)].addr[ADDR_W-1:2] == ld_addr_m[ADDR_W-1:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (ent[rd_idx + IW'(k)].byteen[b]) begin
            fwdbyteen[b]      = 1'b1;
            fwddata[8*b +: 8] = ent[rd_idx + IW'(k)].data[8*b +: 8];
          end
        end
      end
    end
  end
endmodule

// File: rtl/rvdff.sv
// rtl/rvdff.sv - basic async active-low reset flops, free-running and enabled
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  // capture every cycle, clear on reset
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dout <= '0;
    else        dout <= din;
  end
endmodule

module rvdffe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  // capture only when enabled, clear on reset
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)  dout <= '0;
    else if (en) dout <= din;
  end
endmodule

// File: rtl/el2_lsu_stq.sv
// rtl/el2_lsu_stq.sv - committed-store queue: allocate, coalesce, in-order drain, forward
module el2_lsu_stq
  import el2_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  el2_lsu_stq_if.slave      stq,
  input  logic              dec_tlu_force_halt,
  output logic              lsu_stbuf_empty_any,
  output logic              stbuf_full,
  output logic              stbuf_ovf_err,
  input  logic [ADDR_W-1:0] ld_addr_m,
  output logic [31:0]       stbuf_fwddata_m,
  output logic [3:0]        stbuf_fwdbyteen_m
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  el2_stq_entry_t    ent [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count;
  logic [IW-1:0]     wr_idx, rd_idx, y_idx;
  logic [ADDR_W-3:0] st_word;
  logic              halt, head_vld, commit_ok, coalesce, push, ovf_set, ovf_nxt;
  logic              unused_st_lsbs;

  assign unused_st_lsbs = ^stq.store_addr_r[1:0];

  assign halt    = dec_tlu_force_halt;
  assign wr_idx  = wr_ptr[IW-1:0];
  assign rd_idx  = rd_ptr[IW-1:0];
  assign y_idx   = wr_idx - IW'(1);
  assign count   = wr_ptr - rd_ptr;
  assign st_word = stq.store_addr_r[ADDR_W-1:2];

  // Allocation decision: coalesce into a non-head youngest entry, else push, else drop.
  always_comb begin
    head_vld   = (ent[rd_idx].state == VLD);
    commit_ok  = stq.lsu_stbuf_commit_any & head_vld & ~halt;
    coalesce   = stq.ldst_stbuf_reqvld_r & ~halt & (count > PW'(1)) &
                 (ent[y_idx].addr[ADDR_W-1:2] == st_word);
    push       = stq.ldst_stbuf_reqvld_r & ~halt & ~coalesce &
                 ((count != PW'(DEPTH)) | commit_ok);
    ovf_set    = stq.ldst_stbuf_reqvld_r & ~halt & ~coalesce & ~push;
    ovf_nxt    = stbuf_ovf_err | ovf_set;
    wr_ptr_nxt = halt ? '0 : wr_ptr + PW'(push);
    rd_ptr_nxt = halt ? '0 : rd_ptr + PW'(commit_ok);
  end

  rvdff #(.WIDTH(PW)) u_wr_ptr (.clk(clk), .rst_l(rst_l), .din(wr_ptr_nxt), .dout(wr_ptr));
  rvdff #(.WIDTH(PW)) u_rd_ptr (.clk(clk), .rst_l(rst_l), .din(rd_ptr_nxt), .dout(rd_ptr));
  rvdff #(.WIDTH(1))  u_ovf    (.clk(clk), .rst_l(rst_l), .din(ovf_nxt),    .dout(stbuf_ovf_err));

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    el2_stq_state_e    st_q, st_nxt;
    logic [0:0]        st_raw;
    logic              alloc_i, merge_i, pl_en;
    logic [ADDR_W-3:0] word_q;
    logic [31:0]       data_q, data_nxt;
    logic [3:0]        be_q, be_nxt;

    assign alloc_i = push & (wr_idx == IW'(i));
    assign merge_i = coalesce & (y_idx == IW'(i));
    assign pl_en   = alloc_i | merge_i;

    // Entry FSM next state: halt clears, allocation wins over a same-slot commit.
    always_comb begin
      st_nxt = st_q;
      if (halt)                                  st_nxt = IDLE;
      else if (alloc_i)                          st_nxt = VLD;
      else if (commit_ok && rd_idx == IW'(i))    st_nxt = IDLE;
    end

    rvdff #(.WIDTH(1)) u_st (.clk(clk), .rst_l(rst_l), .din(st_nxt), .dout(st_raw));
    assign st_q = el2_stq_state_e'(st_raw);

    // New payload: fresh store on allocation, byte-merged into the old one on coalesce.
    always_comb begin
      be_nxt   = alloc_i ? stq.store_byteen_r : (be_q | stq.store_byteen_r);
      data_nxt = data_q;
      for (int b = 0; b < 4; b++) begin
        if (alloc_i || stq.store_byteen_r[b]) data_nxt[8*b +: 8] = stq.store_data_r[8*b +: 8];
      end
    end

    rvdffe #(.WIDTH(ADDR_W-2+36)) u_pl (
      .clk(clk), .rst_l(rst_l), .en(pl_en),
      .din({st_word, data_nxt, be_nxt}),
      .dout({word_q, data_q, be_q})
    );

    assign ent[i] = '{addr:   EL2_STQ_MAX_ADDR_W'({word_q, 2'b00}),
                      data:   data_q,
                      byteen: be_q,
                      state:  st_q};
  end

  assign lsu_stbuf_empty_any  = (count == '0);
  assign stbuf_full           = (count == PW'(DEPTH));
  assign stq.stbuf_reqvld_any = head_vld;
  assign stq.stbuf_addr_any   = head_vld ? ent[rd_idx].addr[ADDR_W-1:0] : '0;
  assign stq.stbuf_data_any   = head_vld ? ent[rd_idx].data : '0;
  assign stq.stbuf_byteen_any = head_vld ? ent[rd_idx].byteen : '0;

  el2_lsu_stq_fwd #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fwd (
    .ent       (ent),
    .rd_idx    (rd_idx),
    .ld_addr_m (ld_addr_m),
    .fwddata   (stbuf_fwddata_m),
    .fwdbyteen (stbuf_fwdbyteen_m)
  );
endmodule

// File: tb/tb_el2_lsu_stq.sv
// tb/tb_el2_lsu_stq.sv - directed self-checking bench for el2_lsu_stq
module tb_el2_lsu_stq;
  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] ld_addr = '0;
  logic        empty, full, ovf;
  logic [31:0] fwddata;
  logic [3:0]  fwdbe;
  int          n_checks = 0;
  int          n_errs = 0;

  el2_lsu_stq_if #(.ADDR_W(16)) bus ();

  el2_lsu_stq #(.DEPTH(4), .ADDR_W(16)) dut (
    .clk                 (clk),
    .rst_l               (rst_l),
    .stq                 (bus),
    .dec_tlu_force_halt  (halt),
    .lsu_stbuf_empty_any (empty),
    .stbuf_full          (full),
    .stbuf_ovf_err       (ovf),
    .ld_addr_m           (ld_addr),
    .stbuf_fwddata_m     (fwddata),
    .stbuf_fwdbyteen_m   (fwdbe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.ldst_stbuf_reqvld_r  = 1'b0;
    bus.lsu_stbuf_commit_any = 1'b0;
    halt = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.ldst_stbuf_reqvld_r = 1'b1;
    bus.store_addr_r        = a;
    bus.store_data_r        = d;
    bus.store_byteen_r      = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ldst_stbuf_reqvld_r  = 1'b0;
    bus.store_addr_r         = '0;
    bus.store_data_r         = '0;
    bus.store_byteen_r       = '0;
    bus.lsu_stbuf_commit_any = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty",  empty, 1);
    check("rst_reqvld", bus.stbuf_reqvld_any, 0);
    check("rst_full",   full, 0);
    check("rst_ovf",    ovf, 0);
    check("rst_addr",   bus.stbuf_addr_any, 0);
    check("rst_data",   bus.stbuf_data_any, 0);
    check("rst_fwdbe",  fwdbe, 0);
    @(negedge clk);
    rst_l = 1'b1;

    // single store then commit
    store(16'h0100, 32'hAABBCCDD, 4'hF); tick();
    check("t1_reqvld", bus.stbuf_reqvld_any, 1);
    check("t1_addr",   bus.stbuf_addr_any, 32'h0100);
    check("t1_data",   bus.stbuf_data_any, 32'hAABBCCDD);
    check("t1_be",     bus.stbuf_byteen_any, 4'hF);
    check("t1_empty",  empty, 0);
    bus.lsu_stbuf_commit_any = 1'b1; tick();
    check("t1_empty_after", empty, 1);
    check("t1_reqvld_after", bus.stbuf_reqvld_any, 0);

    // coalescing behind a busy head
    store(16'h0100, 32'h0, 4'hF); tick();
    store(16'h0104, 32'h00001122, 4'h3); tick();
    store(16'h0104, 32'h33440000, 4'hC); tick();
    ld_addr = 16'h0104; #1;
    check("t2_fwdbe",   fwdbe, 4'hF);
    check("t2_fwddata", fwddata, 32'h33441122);
    check("t2_head",    bus.stbuf_addr_any, 32'h0100);
    bus.lsu_stbuf_commit_any = 1'b1; tick();
    check("t2_head2",   bus.stbuf_addr_any, 32'h0104);
    check("t2_data2",   bus.stbuf_data_any, 32'h33441122);
    check("t2_be2",     bus.stbuf_byteen_any, 4'hF);
    bus.lsu_stbuf_commit_any = 1'b1; tick();
    check("t2_empty",   empty, 1);

    // same word as the head must not coalesce
    store(16'h0108, 32'h00000011, 4'h1); tick();
    store(16'h0108, 32'h00002200, 4'h2); tick();
    bus.lsu_stbuf_commit_any = 1'b1; tick();
    check("nh_empty", empty, 0);
    check("nh_addr",  bus.stbuf_addr_any, 32'h0108);
    check("nh_data",  bus.stbuf_data_any, 32'h00002200);
    check("nh_be",    bus.stbuf_byteen_any, 4'h2);
    bus.lsu_stbuf_commit_any = 1'b1; tick();
    check("nh_empty2", empty, 1);

    // fill, accept-with-commit when full, then overflow
    for (int k = 0; k < 4; k++) begin
      store(16'h0010 + 16'(4*k), 32'(k), 4'hF); tick();
    end
    check("t3_full", full, 1);
    check("t3_ovf0", ovf, 0);
    store(16'h0020, 32'h20, 4'hF); bus.lsu_stbuf_commit_any = 1'b1; tick();
    check("t3_full_cmt", full, 1);
    check("t3_ovf_cmt",  ovf, 0);
    check("t3_head_cmt", bus.stbuf_addr_any, 32'h0014);
    store(16'h0024, 32'h24, 4'hF); tick();
    check("t3_ovf1",  ovf, 1);
    check("t3_full2", full, 1);
    ld_addr = 16'h0024; #1;
    check("t3_drop_fwd", fwdbe, 0);
    for (int k = 0; k < 4; k++) begin
      check("t3_drain_addr", bus.stbuf_addr_any, 32'h0014 + 32'(4*k));
      bus.lsu_stbuf_commit_any = 1'b1; tick();
    end
    check("t3_empty", empty, 1);
    check("t3_nfull", full, 0);

    // youngest-wins forwarding
    store(16'h0200, 32'h11111111, 4'hF); tick();
    store(16'h0300, 32'h22222222, 4'hF); tick();
    store(16'h0200, 32'h000000EE, 4'h1); tick();
    ld_addr = 16'h0202; #1;
    check("t4_be",    fwdbe, 4'hF);
    check("t4_data",  fwddata, 32'h111111EE);
    ld_addr = 16'h0300; #1;
    check("t4_be3",   fwdbe, 4'hF);
    check("t4_data3", fwddata, 32'h22222222);
    ld_addr = 16'h0400; #1;
    check("t4_miss_be",   fwdbe, 0);
    check("t4_miss_data", fwddata, 0);
    store(16'h0400, 32'h44444444, 4'hF); #1;
    check("t4_samecyc_be", fwdbe, 0);
    tick();
    check("t4_new_be",   fwdbe, 4'hF);
    check("t4_new_data", fwddata, 32'h44444444);
    check("t4_full",     full, 1);

    // force halt with a same-cycle allocation
    halt = 1'b1; store(16'h0500, 32'h55, 4'hF); tick();
    check("t5_empty",  empty, 1);
    check("t5_reqvld", bus.stbuf_reqvld_any, 0);
    check("t5_full",   full, 0);
    check("t5_ovf",    ovf, 1);
    check("t5_fwd",    fwdbe, 0);
    store(16'h0600, 32'h66, 4'hF); tick();
    check("t5_head", bus.stbuf_addr_any, 32'h0600);
    bus.lsu_stbuf_commit_any = 1'b1; tick();
    check("t5_empty2", empty, 1);

    // asynchronous reset mid-cycle
    store(16'h0700, 32'h77, 4'hF); tick();
    check("t6_pre", empty, 0);
    #2 rst_l = 1'b0;
    #1;
    check("t6_empty",  empty, 1);
    check("t6_ovf",    ovf, 0);
    check("t6_reqvld", bus.stbuf_reqvld_any, 0);
    @(negedge clk);
    rst_l = 1'b1;

    // wrap-around with back-to-back store/commit
    store(16'h1000, 32'h0, 4'hF); tick();
    for (int k = 1; k < 10; k++) begin
      store(16'h1000 + 16'(4*k), 32'(k), 4'hF);
      bus.lsu_stbuf_commit_any = 1'b1;
      tick();
      check("t7_addr",  bus.stbuf_addr_any, 32'h1000 + 32'(4*k));
      check("t7_data",  bus.stbuf_data_any, 32'(k));
      check("t7_empty", empty, 0);
    end
    bus.lsu_stbuf_commit_any = 1'b1; tick();
    check("t7_final_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/el2_lsu_stq.md
# el2_lsu_stq

Committed-store queue for the EL2 LSU. It accepts stores at the R stage, coalesces same-word stores, and drains entries in order to the DCCM port. It forwards pending store bytes to loads in M. Its status outputs (`stbuf_reqvld_any`, `lsu_stbuf_empty_any`) feed the LSU clock-domain block directly: they keep `lsu_stbuf_c1_clk` and `lsu_free_c2_clk` running while stores are pending.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of 2, ≥2.
- `ADDR_W`, 16: DCCM byte-address width.

Ports:
- `clk` in 1: core clock (LSU stbuf gated clock domain).
- `rst_l` in 1: reset, asynchronous, active-low.
- `dec_tlu_force_halt` in 1: discard all entries.
- `ldst_stbuf_reqvld_r` in 1: allocate a store this cycle.
- `store_addr_r` in ADDR_W: store byte address; bits [1:0] ignored.
- `store_data_r` in 32: store data, word-aligned lanes.
- `store_byteen_r` in 4: byte enables.
- `stbuf_reqvld_any` out 1: head entry requests DCCM write.
- `stbuf_addr_any` out ADDR_W: head word address, bits [1:0] = 0.
- `stbuf_data_any` out 32: head data.
- `stbuf_byteen_any` out 4: head byte enables.
- `lsu_stbuf_commit_any` in 1: DCCM accepted the head this cycle.
- `lsu_stbuf_empty_any` out 1: no valid entries.
- `stbuf_full` out 1: count == DEPTH.
- `stbuf_ovf_err` out 1: sticky; allocation was dropped.
- `ld_addr_m` in ADDR_W: load address in M.
- `stbuf_fwddata_m` out 32: forwarded bytes.
- `stbuf_fwdbyteen_m` out 4: which bytes are forwarded.

## Operation
- Circular FIFO with `wr_ptr` and `rd_ptr`, each log2(DEPTH)+1 bits; the MSB disambiguates full from empty and pointers wrap modulo 2·DEPTH.
- Count = wr_ptr − rd_ptr.
- Each entry runs a two-state FSM, IDLE and VLD:
  - IDLE→VLD on allocation.
  - VLD→IDLE when it is the head and `lsu_stbuf_commit_any` is asserted.
  - A VLD entry's byteen is updated in place on coalescing.
- Allocation when `ldst_stbuf_reqvld_r` is asserted, in priority order:
  1. Coalesce: if the youngest valid entry has the same word address and is not the head, OR its byteen with `store_byteen_r` and overwrite the enabled bytes. Pointers do not move.
  2. Otherwise, if not full (or full with a same-cycle commit), write at `wr_ptr` and increment it.
  3. Otherwise drop the store and set `stbuf_ovf_err`, which holds until reset.
- Drain:
  - `stbuf_reqvld_any` = head VLD.
  - Payload is stable while reqvld is high and there is no commit.
  - Commit increments `rd_ptr`.
  - `lsu_stbuf_commit_any` while empty is ignored.
- Forwarding (combinational, registered entries only):
  - Per byte lane, take the youngest VLD entry whose word address == `ld_addr_m[ADDR_W-1:2]` and whose byteen bit is set.
  - The same-cycle allocation is not visible.
  - With no match, data = 0 and byteen = 0.
- `dec_tlu_force_halt` has priority over everything: all entries go IDLE and `wr_ptr = rd_ptr = 0` at the next edge. Allocation and commit in that cycle are ignored; `stbuf_ovf_err` is unchanged.

## Timing
- Reset values:
  - All entries IDLE, pointers 0.
  - `lsu_stbuf_empty_any` = 1.
  - `stbuf_reqvld_any`, `stbuf_full`, `stbuf_ovf_err` = 0.
  - Payload and forward outputs = 0.
- Allocation at edge N makes the entry visible at cycle N+1: empty=0, reqvld=1 if it is the head, forwarding active.
- Minimum allocate-to-commit latency is 1 cycle; sustained throughput is 1 store/cycle.
- Commit at N frees the head at N+1; the next entry's payload is presented at N+1.
- Simultaneous allocation and commit at count=DEPTH: both are accepted and count stays DEPTH.
- Simultaneous allocation and commit at count=1: the head drains and the new entry becomes head at N+1. Coalescing into the head is never allowed.
- Asynchronous reset mid-operation clears all state immediately and discards queued stores.

## Structure
- `el2_pkg` holds:
  - `el2_stq_entry_t` with fields `addr`, `data[31:0]`, `byteen[3:0]`, `state`.
  - `el2_stq_state_e` with values IDLE and VLD.
- Sub-module `el2_lsu_stq_fwd`: purely combinational youngest-wins per-byte forwarding mux over DEPTH entries, parameterised by DEPTH and ADDR_W.
- All flops are `rvdff`/`rvdffe` instances using the async active-low reset.

## Test plan
- Store A=0x0100, data 0xAABBCCDD, byteen 0xF → next cycle: reqvld=1, addr 0x0100, empty=0. Commit → empty=1 one cycle later.
- Two stores to 0x0104: first byteen 0x3, data 0x00001122; second byteen 0xC, data 0x33440000; head busy with 0x0100 → single entry byteen 0xF, data 0x33441122, count 2.
- Fill 4 distinct addresses with no commit → full=1. Fifth store → dropped, `stbuf_ovf_err`=1, count 4. Fifth store with a same-cycle commit → accepted, no error.
- Entries 0x0200 (byteen 0xF, 0x11111111) and later 0x0200 at head+2 (byteen 0x1, 0x000000EE); load 0x0202 → fwdbyteen 0xF, fwddata 0x111111EE.
- Three valid entries, `dec_tlu_force_halt` pulsed with an allocation in the same cycle → next cycle empty=1, reqvld=0, pointers 0.
- Wrap-around: 10 store/commit pairs with DEPTH=4 → FIFO order preserved, each addr committed exactly once.
